// File: rtl/letter_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : letter_pkg
// Description : Shared types and constants for the letter scan controller:
//               controller state encoding, letter codes understood by the
//               downstream 7-segment letter decoder, and the blank anode word.
// Revision    : 1.0 - initial release
// ============================================================================
package letter_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STATIC = 2'd1,
        SCROLL = 2'd2
    } state_t;

    // Letter codes accepted by the decoder (code 0 = a ... code 15 = y)
    localparam logic [3:0] L_A = 4'd0;
    localparam logic [3:0] L_B = 4'd1;
    localparam logic [3:0] L_C = 4'd2;
    localparam logic [3:0] L_D = 4'd3;
    localparam logic [3:0] L_E = 4'd4;
    localparam logic [3:0] L_F = 4'd5;
    localparam logic [3:0] L_G = 4'd6;
    localparam logic [3:0] L_H = 4'd7;
    localparam logic [3:0] L_I = 4'd8;
    localparam logic [3:0] L_L = 4'd9;
    localparam logic [3:0] L_N = 4'd10;
    localparam logic [3:0] L_O = 4'd11;
    localparam logic [3:0] L_P = 4'd12;
    localparam logic [3:0] L_R = 4'd13;
    localparam logic [3:0] L_U = 4'd14;
    localparam logic [3:0] L_Y = 4'd15;

    // All anodes disabled (anodes are active-low)
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Longest message the buffer can hold
    localparam logic [4:0] MAX_LEN = 5'd16;

    // Active-low anode word that lights exactly one slot
    function automatic logic [3:0] an_select(input logic [1:0] slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage : letter_pkg
`default_nettype wire

// File: rtl/letter_scan_ctrl_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : tick_div
// Description : Free-running modulo-N counter with synchronous clear and
//               count enable. tick_o is high for the single enabled cycle in
//               which the counter sits at N-1; the counter then wraps to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_div #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next count: clear has priority, otherwise advance and wrap while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_div
`default_nettype wire

// File: rtl/letter_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : letter_scan_ctrl
// Description : Scans a 4-digit 7-segment display from a 16-entry message
//               buffer of letter codes. Shows the first four characters
//               (blanking past the message end) or scrolls longer messages
//               left with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module letter_scan_ctrl
    import letter_pkg::*;
#(
    parameter int DIGIT_TICKS  = 100000,
    parameter int SCROLL_TICKS = 50000000,
    parameter int MSG_DEPTH    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [3:0] wr_addr_i,
    input  logic [3:0] wr_data_i,
    input  logic [4:0] msg_len_i,
    input  logic       scroll_en_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic [3:0] letter_o,
    output logic [3:0] an_o,
    output logic       active_o,
    output logic       step_o
);

    // Message storage (not reset)
    logic [3:0] buf_q [MSG_DEPTH];

    state_t     state_q,  state_d;
    logic [4:0] len_q,    len_d;
    logic [1:0] slot_q,   slot_d;
    logic [3:0] ptr_q,    ptr_d;
    logic [3:0] letter_q, letter_d;
    logic [3:0] an_q,     an_d;
    logic       step_q,   step_d;

    logic       digit_tick;
    logic       scroll_tick;
    logic [4:0] len_clamped;
    logic [4:0] ptr_inc;
    logic [4:0] idx_sum;
    logic [4:0] idx_sel;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic       lit;

    // Digit-dwell timer: runs only while the display is lit
    tick_div #(.N(DIGIT_TICKS)) u_digit_div (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (start_i || stop_i || (state_q == IDLE)),
        .en_i   (state_q != IDLE),
        .tick_o (digit_tick)
    );

    // Scroll-step timer: runs only in SCROLL
    tick_div #(.N(SCROLL_TICKS)) u_scroll_div (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (start_i || stop_i || (state_q != SCROLL)),
        .en_i   (state_q == SCROLL),
        .tick_o (scroll_tick)
    );

    assign len_clamped = (msg_len_i > MAX_LEN) ? MAX_LEN : msg_len_i;
    assign ptr_inc     = {1'b0, ptr_q} + 5'd1;

    // Message buffer write port, open in every state
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            buf_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Next state, length, slot and scroll pointer; stop beats start
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        slot_d  = slot_q;
        ptr_d   = ptr_q;
        step_d  = 1'b0;
        if (stop_i) begin
            state_d = IDLE;
            slot_d  = 2'd0;
            ptr_d   = 4'd0;
        end else if (start_i) begin
            len_d  = len_clamped;
            ptr_d  = 4'd0;
            if (len_clamped == 5'd0) begin
                state_d = IDLE;
                slot_d  = 2'd0;
            end else begin
                state_d = (scroll_en_i && (len_clamped >= 5'd5)) ? SCROLL : STATIC;
                slot_d  = 2'd3;
            end
        end else begin
            if ((state_q != IDLE) && digit_tick) begin
                slot_d = slot_q - 2'd1;
            end
            if ((state_q == SCROLL) && scroll_tick) begin
                ptr_d  = (ptr_inc == len_q) ? 4'd0 : ptr_inc[3:0];
                step_d = 1'b1;
            end
        end
    end

    // Character index for the slot being lit next; slot p shows ptr + (3-p).
    // In SCROLL one conditional subtract suffices since ptr < len and len >= 5.
    always_comb begin
        idx_sum = {1'b0, ptr_d} + {3'b000, ~slot_d};
        idx_sel = idx_sum;
        if ((state_d == SCROLL) && (idx_sum >= len_d)) begin
            idx_sel = idx_sum - len_d;
        end
        rd_addr = idx_sel[3:0];
        lit     = (state_d != IDLE) && (idx_sel < len_d);
    end

    // Buffer read with write bypass so a same-cycle write is shown at once
    always_comb begin
        rd_data = buf_q[rd_addr];
        if (wr_en_i && (wr_addr_i == rd_addr)) begin
            rd_data = wr_data_i;
        end
    end

    // Registered display word: lit slot or blank
    always_comb begin
        letter_d = L_A;
        an_d     = AN_OFF;
        if (lit) begin
            letter_d = rd_data;
            an_d     = an_select(slot_d);
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= 5'd0;
            slot_q   <= 2'd0;
            ptr_q    <= 4'd0;
            letter_q <= L_A;
            an_q     <= AN_OFF;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            slot_q   <= slot_d;
            ptr_q    <= ptr_d;
            letter_q <= letter_d;
            an_q     <= an_d;
            step_q   <= step_d;
        end
    end

    assign letter_o = letter_q;
    assign an_o     = an_q;
    assign active_o = (state_q != IDLE);
    assign step_o   = step_q;

endmodule : letter_scan_ctrl
`default_nettype wire

// File: tb/tb_letter_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_letter_scan_ctrl
// Description : Scoreboard bench for letter_scan_ctrl. The stimulus process
//               queues the expected display word for specific cycles; a
//               monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_letter_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] wr_data = 4'd0;
    logic [4:0] msg_len = 5'd0;
    logic       scroll_en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] letter;
    logic [3:0] an;
    logic       active;
    logic       step;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] letter;
        logic       active;
        logic       step;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    letter_scan_ctrl #(
        .DIGIT_TICKS  (4),
        .SCROLL_TICKS (64),
        .MSG_DEPTH    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .msg_len_i   (msg_len),
        .scroll_en_i (scroll_en),
        .start_i     (start),
        .stop_i      (stop),
        .letter_o    (letter),
        .an_o        (an),
        .active_o    (active),
        .step_o      (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation due in this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            n_tests++;
            if (mon_e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (an !== mon_e.an || letter !== mon_e.letter ||
                         active !== mon_e.active || step !== mon_e.step) begin
                n_fail++;
                $display("FAIL %s @%0d: got an=%b letter=%0d active=%b step=%b, want an=%b letter=%0d active=%b step=%b",
                         mon_e.name, cyc, an, letter, active, step,
                         mon_e.an, mon_e.letter, mon_e.active, mon_e.step);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] a, input logic [3:0] l,
                        input logic act, input logic st, input string nm);
        exp_t e;
        e.cyc = c; e.an = a; e.letter = l; e.active = act; e.step = st; e.name = nm;
        q.push_back(e);
    endtask

    // One 16-cycle frame: lets holds slot3..slot0 letters, lit marks lit slots
    task automatic push_frame(input int t, input logic [15:0] lets, input logic [3:0] lit,
                              input logic st0, input string nm);
        logic [3:0] an_seq [4];
        an_seq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        for (int j = 0; j < 16; j++) begin
            int k;
            k = j / 4;
            push(t + j, lit[3-k] ? an_seq[k] : 4'hF, lets[15-4*k -: 4], 1'b1,
                 (j == 0) ? st0 : 1'b0, nm);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len, input logic sc);
        msg_len = len; scroll_en = sc; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    // Watchdog keeps the run bounded
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: run did not finish in time (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int t0;

        // Reset
        repeat (3) tick();
        push(cyc, 4'hF, 4'd0, 1'b0, 1'b0, "reset");
        reset = 1'b0;
        tick();
        push(cyc, 4'hF, 4'd0, 1'b0, 1'b0, "idle_after_reset");
        tick();

        // 1: static "hELp", len 4
        wr(4'd0, 4'd7); wr(4'd1, 4'd4); wr(4'd2, 4'd9); wr(4'd3, 4'd12);
        do_start(5'd4, 1'b0);
        t0 = cyc;
        push_frame(t0,      16'h749C, 4'b1111, 1'b0, "t1_frame0");
        push_frame(t0 + 16, 16'h749C, 4'b1111, 1'b0, "t1_frame1");
        run_until(t0 + 32);

        // 2: static "no", len 2 -> right two slots blank
        wr(4'd0, 4'd10); wr(4'd1, 4'd11);
        do_start(5'd2, 1'b0);
        t0 = cyc;
        push_frame(t0, 16'hAB00, 4'b1100, 1'b0, "t2_len2");
        run_until(t0 + 16);

        // 3: scroll 0..5, len 6
        for (int i = 0; i < 6; i++) wr(4'(i), 4'(i));
        do_start(5'd6, 1'b1);
        t0 = cyc;
        push_frame(t0,       16'h0123, 4'hF, 1'b0, "t3_ptr0");
        push_frame(t0 + 64,  16'h1234, 4'hF, 1'b1, "t3_ptr1");
        push_frame(t0 + 128, 16'h2345, 4'hF, 1'b1, "t3_ptr2");
        push_frame(t0 + 256, 16'h4501, 4'hF, 1'b1, "t3_ptr4");
        push_frame(t0 + 320, 16'h5012, 4'hF, 1'b1, "t3_ptr5");
        push_frame(t0 + 384, 16'h0123, 4'hF, 1'b1, "t3_wrap");
        run_until(t0 + 400);

        // 4: start+stop together at ptr 2 -> stop wins, then clean restart
        do_start(5'd6, 1'b1);
        t0 = cyc;
        push(t0 + 128, 4'b0111, 4'd2, 1'b1, 1'b1, "t4_ptr2_step");
        push(t0 + 129, 4'b0111, 4'd2, 1'b1, 1'b0, "t4_ptr2_hold");
        run_until(t0 + 129);
        msg_len = 5'd6; scroll_en = 1'b1; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        push(cyc,     4'hF, 4'd0, 1'b0, 1'b0, "t4_stop_wins");
        push(cyc + 1, 4'hF, 4'd0, 1'b0, 1'b0, "t4_idle_hold");
        tick(); tick();
        do_start(5'd6, 1'b1);
        push_frame(cyc, 16'h0123, 4'hF, 1'b0, "t4_restart");
        run_until(cyc + 16);

        // 5: write buf[1] in the cycle before slot 2 is selected
        do_start(5'd4, 1'b0);
        t0 = cyc;
        for (int j = 0; j < 4; j++) push(t0 + j, 4'b0111, 4'd0, 1'b1, 1'b0, "t5_slot3");
        run_until(t0 + 3);
        wr(4'd1, 4'd15);
        push(cyc,     4'b1011, 4'd15, 1'b1, 1'b0, "t5_bypass");
        push(cyc + 3, 4'b1011, 4'd15, 1'b1, 1'b0, "t5_slot2_end");
        push(cyc + 4, 4'b1101, 4'd2,  1'b1, 1'b0, "t5_slot1");
        run_until(cyc + 6);

        // 6: len 0 forces / keeps IDLE; len 20 clamps to 16
        do_start(5'd0, 1'b0);
        push(cyc, 4'hF, 4'd0, 1'b0, 1'b0, "t6_len0_force");
        tick();
        do_start(5'd0, 1'b1);
        push(cyc, 4'hF, 4'd0, 1'b0, 1'b0, "t6_len0_stay");
        push(cyc + 3, 4'hF, 4'd0, 1'b0, 1'b0, "t6_len0_hold");
        for (int i = 0; i < 16; i++) wr(4'(i), 4'(i));
        do_start(5'd20, 1'b1);
        t0 = cyc;
        push_frame(t0,        16'h0123, 4'hF, 1'b0, "t6_ptr0");
        push_frame(t0 + 960,  16'hF012, 4'hF, 1'b1, "t6_ptr15");
        push_frame(t0 + 1024, 16'h0123, 4'hF, 1'b1, "t6_wrap");
        run_until(t0 + 1042);

        // Anything still queued was never observed
        if (q.size() != 0) begin
            n_tests += q.size();
            n_fail  += q.size();
            $display("FAIL leftover: %0d expectations not reached, first %s", q.size(), q[0].name);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_letter_scan_ctrl
`default_nettype wire
